// File: rtl/alu_seg7_scan_pkg.sv
// alu_seg7_pkg: opcodes, blank pattern and hex-to-segment table for alu_seg7_scan
package alu_seg7_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    return SEG_LUT[n];
  endfunction
endpackage

// File: rtl/alu_seg7_scan_if.sv
// alu_seg7_scan_if: operand/control inputs and display/flag outputs of alu_seg7_scan
interface alu_seg7_scan_if #(parameter int WIDTH = 8);
  localparam int NUM_DIGITS = WIDTH / 4;
  logic [WIDTH-1:0]      A;
  logic [WIDTH-1:0]      B;
  logic [1:0]            opcode;
  logic                  load;
  logic                  en;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] dig_en;
  logic                  carry;
  logic                  result_valid;
  modport master (output A, B, opcode, load, en, input seg, dig_en, carry, result_valid);
  modport slave (input A, B, opcode, load, en, output seg, dig_en, carry, result_valid);
endinterface

// File: rtl/alu_seg7_scan_hex_to_seg7.sv
// hex_to_seg7: combinational nibble-to-segment decoder
module hex_to_seg7
  import alu_seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex_to_seg(nib_i);
endmodule

// File: rtl/alu_seg7_scan.sv
// alu_seg7_scan: ALU with registered result scanned as hex digits; LEADING_ZERO_BLANK_EN blanks leading zero digits
module alu_seg7_scan
  import alu_seg7_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 1000
) (
  input logic           clk,
  input logic           rst,
  alu_seg7_scan_if.slave bus
);
  localparam int NUM_DIGITS = WIDTH / 4;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [WIDTH:0]        sum;
  logic [WIDTH-1:0]      result_d, result_q;
  logic                  carry_d, carry_q, valid_q;
  logic                  psc_wrap;
  logic [PW-1:0]         psc_d, psc_q;
  logic [IW-1:0]         idx_d, idx_q;
  logic [3:0]            nib;
  logic [6:0]            hex, seg_d, seg_q;
  logic [NUM_DIGITS-1:0] dig_en_d, dig_en_q;
  logic                  blank;
  // ALU result and carry/no-borrow flag for the current operands
  always_comb begin
    sum      = {1'b0, bus.A} + {1'b0, bus.B};
    result_d = bus.opcode == OP_ADD ? sum[WIDTH-1:0] :
               bus.opcode == OP_SUB ? bus.A - bus.B :
               bus.opcode == OP_AND ? bus.A & bus.B : bus.A | bus.B;
    carry_d  = bus.opcode == OP_ADD ? sum[WIDTH] :
               bus.opcode == OP_SUB ? bus.A >= bus.B : 1'b0;
  end
  // free-running prescaler advances the digit index once per refresh period
  always_comb begin
    psc_wrap = psc_q == PW'(REFRESH_DIV - 1);
    psc_d    = psc_wrap ? '0 : psc_q + 1'b1;
    idx_d    = !psc_wrap ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
  end
  assign nib = result_q[{idx_q, 2'b00} +: 4];
  hex_to_seg7 u_dec (.nib_i(nib), .seg_o(hex));
`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;
  // digits above the highest non-zero nibble are blanked; digit 0 always shows
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) msd = result_q[4*i +: 4] != 4'h0 ? IW'(i) : msd;
    blank = idx_q > msd;
  end
`else
  assign blank = 1'b0;
`endif
  // output stage inputs: en gates both segments and digit enables
  always_comb begin
    seg_d    = bus.en && !blank ? hex : SEG_BLANK;
    dig_en_d = bus.en ? NUM_DIGITS'(1) << idx_q : '0;
  end
  // result capture, scan counters and registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
      psc_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_BLANK;
      dig_en_q <= '0;
    end else begin
      if (bus.load) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        valid_q  <= 1'b1;
      end
      psc_q    <= psc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
    end
  end
  assign bus.seg          = seg_q;
  assign bus.dig_en       = dig_en_q;
  assign bus.carry        = carry_q;
  assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_alu_seg7_scan.sv
// tb_alu_seg7_scan: directed-vector bench for alu_seg7_scan (WIDTH=8, REFRESH_DIV=4)
module tb_alu_seg7_scan;
  import alu_seg7_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  alu_seg7_scan_if #(.WIDTH(8)) bus ();
  alu_seg7_scan #(.WIDTH(8), .REFRESH_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.opcode = op;
    bus.load = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask
  task automatic wait_dig(input logic [1:0] d);
    int k = 0;
    @(negedge clk);
    while (bus.dig_en !== d && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("dig_en_wait", bus.dig_en, d);
  endtask
  task automatic show(input string tag, input logic [1:0] d, input logic [6:0] exp_seg);
    wait_dig(d);
    chk(tag, bus.seg, exp_seg);
  endtask
  initial begin
    bus.A = '0;
    bus.B = '0;
    bus.opcode = OP_ADD;
    bus.load = 1'b0;
    bus.en = 1'b1;
    #7;
    chk("rst_seg", bus.seg, 7'h00);
    chk("rst_dig", bus.dig_en, 2'b00);
    chk("rst_carry", bus.carry, 1'b0);
    chk("rst_valid", bus.result_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick(1); chk("scan_first", bus.dig_en, 2'b01);
    tick(3); chk("scan_d0_end", bus.dig_en, 2'b01);
    tick(1); chk("scan_d1", bus.dig_en, 2'b10);
    tick(3); chk("scan_d1_end", bus.dig_en, 2'b10);
    tick(1); chk("scan_wrap", bus.dig_en, 2'b01);
    do_load(8'h3C, 8'h05, OP_ADD);
    chk("add1_carry", bus.carry, 1'b0);
    chk("add1_valid", bus.result_valid, 1'b1);
    tick(1);
    show("add1_d0", 2'b01, 7'h30);
    show("add1_d1", 2'b10, 7'h33);
    do_load(8'hF0, 8'h20, OP_ADD);
    chk("add2_carry", bus.carry, 1'b1);
    tick(1);
    show("add2_d1", 2'b10, 7'h30);
    show("add2_d0", 2'b01, 7'h7E);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_seg", bus.seg, 7'h00);
    chk("mrst_dig", bus.dig_en, 2'b00);
    chk("mrst_carry", bus.carry, 1'b0);
    chk("mrst_valid", bus.result_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick(1); chk("mrst_first", bus.dig_en, 2'b01);
    tick(3); chk("mrst_d0_end", bus.dig_en, 2'b01);
    tick(1); chk("mrst_d1", bus.dig_en, 2'b10);
    do_load(8'h05, 8'h07, OP_SUB);
    chk("sub1_carry", bus.carry, 1'b0);
    tick(1);
    show("sub1_d0", 2'b01, 7'h4F);
    show("sub1_d1", 2'b10, 7'h47);
    do_load(8'h07, 8'h05, OP_SUB);
    chk("sub2_carry", bus.carry, 1'b1);
    tick(1);
    show("sub2_d0", 2'b01, 7'h6D);
    show("sub2_d1", 2'b10, 7'h7E);
    wait_dig(2'b01);
    wait_dig(2'b10);
    bus.en = 1'b0;
    tick(1);
    chk("dis_dig", bus.dig_en, 2'b00);
    chk("dis_seg", bus.seg, 7'h00);
    tick(2);
    chk("dis_dig_hold", bus.dig_en, 2'b00);
    bus.en = 1'b1;
    tick(1);
    chk("ren_dig", bus.dig_en, 2'b01);
    chk("ren_seg", bus.seg, 7'h6D);
    do_load(8'h07, 8'h00, OP_OR);
    chk("or_carry", bus.carry, 1'b0);
    tick(1);
`ifdef LEADING_ZERO_BLANK_EN
    show("lz7_d1", 2'b10, 7'h00);
`else
    show("lz7_d1", 2'b10, 7'h7E);
`endif
    show("lz7_d0", 2'b01, 7'h70);
    do_load(8'h00, 8'h00, OP_AND);
    chk("and_carry", bus.carry, 1'b0);
    tick(1);
    show("zero_d0", 2'b01, 7'h7E);
`ifdef LEADING_ZERO_BLANK_EN
    show("zero_d1", 2'b10, 7'h00);
`else
    show("zero_d1", 2'b10, 7'h7E);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
